// File: rtl/opcode_decode_stage_pkg.sv
// Shared opcode encodings, one-hot opcode class record and the buffered decode entry.
package opcode_type;

   localparam int unsigned ILEN = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic is_lui;
      logic is_auipc;
      logic is_jal;
      logic is_jalr;
      logic is_branch;
      logic is_load;
      logic is_store;
      logic is_imm_arith_type;
      logic is_reg_arith_type;
      logic is_muldiv;
      logic is_fence;
      logic is_system;
   } opcode_t;

   typedef struct packed {
      opcode_t           opcode;
      logic              illegal;
      logic [ILEN-1:0]   instr;
   } dec_entry_t;

endpackage

// File: rtl/opcode_decode_stage_classify.sv
// Combinational opcode classifier: opcode/funct fields -> one-hot class and illegal flag.
module opcode_classify
   import opcode_type::*;
#(
   parameter bit ENABLE_M      = 1'b1,
   parameter bit ENABLE_SYSTEM = 1'b1
) (
   input  logic [6:0] opc,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output opcode_t    opcode_c,
   output logic       illegal_c
);

   always_comb begin
      opcode_c = '0;
      // Every listed opcode ends in 2'b11, so compressed forms fall to the default.
      unique case (opc)
         OPC_LUI:      opcode_c.is_lui            = 1'b1;
         OPC_AUIPC:    opcode_c.is_auipc          = 1'b1;
         OPC_JAL:      opcode_c.is_jal            = 1'b1;
         OPC_JALR:     opcode_c.is_jalr           = (funct3 == 3'b000);
         OPC_BRANCH:   opcode_c.is_branch         = 1'b1;
         OPC_LOAD:     opcode_c.is_load           = 1'b1;
         OPC_STORE:    opcode_c.is_store          = 1'b1;
         OPC_OP_IMM:   opcode_c.is_imm_arith_type = 1'b1;
         OPC_OP: begin
            if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
               opcode_c.is_reg_arith_type = 1'b1;
            end else if (funct7 == F7_MULDIV) begin
               opcode_c.is_muldiv = ENABLE_M;
            end
         end
         OPC_MISC_MEM: opcode_c.is_fence          = 1'b1;
         OPC_SYSTEM:   opcode_c.is_system         = ENABLE_SYSTEM;
         default:      opcode_c                   = '0;
      endcase
      illegal_c = (opcode_c == '0);
   end

endmodule

// File: rtl/opcode_decode_stage.sv
// Registered decode stage: classifies incoming words and holds them in a two-entry
// skid buffer (output register + skid register) behind a registered in_ready.
module opcode_decode_stage
   import opcode_type::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter bit          ENABLE_M      = 1'b1,
   parameter bit          ENABLE_SYSTEM = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output opcode_t         out_opcode,
   output logic            out_illegal,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   dec_entry_t      out_q, out_d;
   dec_entry_t      skid_q, skid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;

   opcode_t         cls_opcode_c;
   logic            cls_illegal_c;
   dec_entry_t      in_entry_c;
   logic            accept_c;
   logic            drain_c;

   opcode_classify #(
      .ENABLE_M      (ENABLE_M),
      .ENABLE_SYSTEM (ENABLE_SYSTEM)
   ) u_classify (
      .opc       (in_instr[6:0]),
      .funct3    (in_instr[14:12]),
      .funct7    (in_instr[31:25]),
      .opcode_c  (cls_opcode_c),
      .illegal_c (cls_illegal_c)
   );

   assign in_entry_c = '{opcode: cls_opcode_c, illegal: cls_illegal_c, instr: in_instr};
   assign accept_c   = in_valid && in_ready_q;
   assign drain_c    = out_valid_q && out_ready;

   // Buffer occupancy and data movement.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      out_pc_d  = out_pc_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  out_d    = in_entry_c;
                  out_pc_d = in_pc;
                  state_d  = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept_c && drain_c) begin
                  out_d    = in_entry_c;
                  out_pc_d = in_pc;
               end else if (accept_c) begin
                  skid_d    = in_entry_c;
                  skid_pc_d = in_pc;
                  state_d   = ST_FULL;
               end else if (drain_c) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain_c) begin
                  out_d    = skid_q;
                  out_pc_d = skid_pc_q;
                  state_d  = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         out_pc_q    <= '0;
         skid_q      <= '0;
         skid_pc_q   <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_pc_q    <= out_pc_d;
         skid_q      <= skid_d;
         skid_pc_q   <= skid_pc_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_opcode  = out_q.opcode;
   assign out_illegal = out_q.illegal;
   assign out_instr   = out_q.instr;
   assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_opcode_decode_stage.sv
// Bench for opcode_decode_stage: two configurations driven in lockstep, checked every
// cycle against a queue-based occupancy model and a rule-based opcode reference.
module tb_opcode_decode_stage;
   import opcode_type::*;

   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } word_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_ready;

   logic            a_in_ready, a_out_valid, a_out_illegal;
   opcode_t         a_out_opcode;
   logic [31:0]     a_out_instr;
   logic [XLEN-1:0] a_out_pc;
   logic            b_in_ready, b_out_valid, b_out_illegal;
   opcode_t         b_out_opcode;
   logic [31:0]     b_out_instr;
   logic [XLEN-1:0] b_out_pc;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   word_t           q[$];
   bit              exp_ready;
   bit              post_rst;
   bit              last_acc;
   int unsigned     n_acc;
   logic [XLEN-1:0] pc_ctr;

   always #5 clk = ~clk;

   opcode_decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b1)) u_dut_full (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_opcode(a_out_opcode),
      .out_illegal(a_out_illegal), .out_instr(a_out_instr), .out_pc(a_out_pc)
   );

   opcode_decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b0), .ENABLE_SYSTEM(1'b0)) u_dut_base (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_opcode(b_out_opcode),
      .out_illegal(b_out_illegal), .out_instr(b_out_instr), .out_pc(b_out_pc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference classification straight from the instruction-set rules.
   function automatic opcode_t ref_class(input logic [31:0] w, input bit en_m, input bit en_sys);
      opcode_t    o;
      logic [2:0] f3;
      logic [6:0] f7;
      o  = '0;
      f3 = w[14:12];
      f7 = w[31:25];
      case (w[6:0])
         7'h37: o.is_lui            = 1'b1;
         7'h17: o.is_auipc          = 1'b1;
         7'h6f: o.is_jal            = 1'b1;
         7'h67: o.is_jalr           = (f3 == 3'd0);
         7'h63: o.is_branch         = 1'b1;
         7'h03: o.is_load           = 1'b1;
         7'h23: o.is_store          = 1'b1;
         7'h13: o.is_imm_arith_type = 1'b1;
         7'h33: begin
            o.is_reg_arith_type = (f7 == 7'h00) || (f7 == 7'h20);
            o.is_muldiv         = (f7 == 7'h01) && en_m;
         end
         7'h0f: o.is_fence          = 1'b1;
         7'h73: o.is_system         = en_sys;
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic check_port(input string who, input bit en_m, input bit en_sys,
                             input logic rdy, input logic vld, input opcode_t opc,
                             input logic ill, input logic [31:0] ins, input logic [XLEN-1:0] pc);
      opcode_t eo;
      chk({who, ".in_ready"}, 64'(rdy), 64'(exp_ready));
      chk({who, ".out_valid"}, 64'(vld), 64'(q.size() != 0));
      if (q.size() != 0) begin
         eo = ref_class(q[0].instr, en_m, en_sys);
         chk({who, ".opcode"}, 64'(opc), 64'(eo));
         chk({who, ".illegal"}, 64'(ill), 64'(eo == '0));
         chk({who, ".instr"}, 64'(ins), 64'(q[0].instr));
         chk({who, ".pc"}, 64'(pc), 64'(q[0].pc));
      end else if (post_rst) begin
         chk({who, ".rst_opcode"}, 64'(opc), 64'd0);
         chk({who, ".rst_illegal"}, 64'(ill), 64'd0);
         chk({who, ".rst_instr"}, 64'(ins), 64'd0);
         chk({who, ".rst_pc"}, 64'(pc), 64'd0);
      end
   endtask

   // Check both DUTs mid-cycle, then advance the model across the next rising edge.
   task automatic cycle();
      bit    acc;
      bit    drn;
      word_t w;
      @(negedge clk);
      check_port("m1", 1'b1, 1'b1, a_in_ready, a_out_valid, a_out_opcode, a_out_illegal,
                 a_out_instr, a_out_pc);
      check_port("m0", 1'b0, 1'b0, b_in_ready, b_out_valid, b_out_opcode, b_out_illegal,
                 b_out_instr, b_out_pc);
      last_acc = 1'b0;
      if (!rst) begin
         q.delete();
         exp_ready = 1'b0;
         post_rst  = 1'b1;
      end else if (flush) begin
         q.delete();
         exp_ready = 1'b1;
      end else begin
         acc = in_valid && exp_ready;
         drn = (q.size() != 0) && out_ready;
         if (drn) void'(q.pop_front());
         if (acc) begin
            w.instr = in_instr;
            w.pc    = in_pc;
            q.push_back(w);
            post_rst = 1'b0;
            n_acc++;
         end
         last_acc  = acc;
         exp_ready = (q.size() < 2);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] w);
      int unsigned waited;
      in_valid = 1'b1;
      in_instr = w;
      in_pc    = pc_ctr;
      pc_ctr   = pc_ctr + XLEN'(4);
      waited   = 0;
      do begin
         cycle();
         waited++;
      end while (!last_acc && waited < 20);
      chk("offer_accepted", 64'(last_acc), 64'd1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  opcs [11];
      int unsigned k;
      opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
      w = $urandom();
      k = $urandom_range(0, 13);
      if (k < 11) w[6:0] = opcs[k];
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         2: w[31:25] = 7'h01;
         default: ;
      endcase
      if ($urandom_range(0, 2) == 0) w[14:12] = 3'd0;
      return w;
   endfunction

   initial begin
      int unsigned start_acc;
      int unsigned budget;
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00500093;
      in_pc     = '0;
      out_ready = 1'b1;
      pc_ctr    = XLEN'(32'h1000);
      q.delete();
      exp_ready = 1'b0;
      post_rst  = 1'b1;
      last_acc  = 1'b0;
      n_acc     = 0;
      @(posedge clk);
      #1;

      // Reset held with a word offered, then released.
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();

      // Back-to-back basic stream.
      offer(32'h00500093);
      offer(32'h123450b7);
      offer(32'h002081b3);
      in_valid = 1'b0;
      repeat (3) cycle();

      // Extension / illegal encodings.
      offer(32'h02208133);
      offer(32'h00000001);
      offer(32'h0000007f);
      offer(32'h00000073);
      offer(32'h00001067);
      offer(32'h000000e7);
      offer(32'h0000100f);
      offer(32'h40208133);
      offer(32'h04208133);
      in_valid = 1'b0;
      repeat (3) cycle();

      // Back-pressure: two accepted, third waits until release.
      out_ready = 1'b0;
      offer(32'h00100113);
      offer(32'h00200193);
      in_valid = 1'b1;
      in_instr = 32'h00300213;
      repeat (3) cycle();
      chk("bp_ready_low", 64'(a_in_ready), 64'd0);
      out_ready = 1'b1;
      offer(32'h00300213);
      in_valid = 1'b0;
      repeat (4) cycle();

      // Flush while full with a word offered.
      out_ready = 1'b0;
      offer(32'h00400293);
      offer(32'h00500313);
      in_valid = 1'b1;
      in_instr = 32'h00600393;
      flush    = 1'b1;
      cycle();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();

      // Randomized traffic.
      start_acc = n_acc;
      budget    = 0;
      in_valid  = 1'b0;
      while ((n_acc - start_acc) < 10000 && budget < 60000) begin
         rst       = ($urandom_range(0, 2999) != 0);
         flush     = ($urandom_range(0, 499) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_instr = rand_instr();
            in_pc    = pc_ctr;
            pc_ctr   = pc_ctr + XLEN'(4);
         end
         cycle();
         budget++;
      end
      chk("rand_words_done", 64'((n_acc - start_acc) >= 10000), 64'd1);
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/opcode_decode_stage.md
# opcode_decode_stage

Registered, flow-controlled instruction decode stage that replaces the bare opcode classifier in the decode path. It accepts a fetched instruction word plus PC over a valid/ready handshake, classifies the opcode into an `opcode_t` one-hot record, flags illegal encodings, and presents the result one cycle later. A two-entry skid buffer sustains one instruction per cycle under back-pressure with a registered `in_ready`. It sits between fetch and register-read, and supports flush on redirect.

## Interface
Parameters:
- `XLEN`, 32: PC width in bits.
- `ENABLE_M`, 1: when 1, OP-opcode words with funct7=0000001 decode as M-extension (`is_muldiv`); when 0 they are illegal.
- `ENABLE_SYSTEM`, 1: when 0, opcode 1110011 is illegal.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous discard of all buffered entries.
- `in_valid`  in  1  instruction word offered.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  consumer accepts entry.
- `out_opcode`  out  opcode_t  one-hot opcode class.
- `out_illegal`  out  1  encoding is illegal; `out_opcode` is all-zero when set.
- `out_instr`  out  32  instruction word, passed through.
- `out_pc`  out  XLEN  PC, passed through.

## Operation
- Classification of `in_instr[6:0]`: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (fence), SYSTEM; exactly one `opcode_t` bit set for legal words.
- Illegal when: `in_instr[1:0]` != 2'b11; opcode not in the list; OP with funct7 not in {0000000, 0100000, 0000001}; OP with funct7=0000001 and `ENABLE_M`=0; SYSTEM with `ENABLE_SYSTEM`=0; JALR with funct3 != 000.
- OP with funct7=0000001 and `ENABLE_M`=1: `is_reg_arith_type`=0, `is_muldiv`=1.
- Illegal entries flow through the pipeline like legal ones (trap raised downstream); they are never dropped.
- Buffer states: EMPTY (no entries), ONE (output register valid), FULL (output + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> FULL; drain without accept -> EMPTY; both -> ONE with new entry.
  - FULL: drain -> ONE (skid moves to output); no accept possible.
- `in_ready` = registered (state != FULL next cycle).
- Order strictly preserved; no entry duplicated or lost except by flush/reset.

## Timing
- Latency: word accepted on edge N (`in_valid && in_ready`) is on outputs after edge N, i.e. visible in cycle N+1.
- Throughput: 1 per cycle while `out_ready`=1.
- `out_valid` once asserted holds, with outputs stable, until `out_ready`=1 on an edge.
- `in_ready` deasserts the cycle after state becomes FULL; the skid absorbs the one word accepted while `in_ready` was still high.
- Reset (`rst`=0 at edge): state EMPTY; `out_valid`=0, `in_ready`=0, `out_opcode`=all zero, `out_illegal`=0, `out_instr`=0, `out_pc`=0. `in_ready`=1 the cycle after the first edge with `rst`=1. Reset mid-stream discards all entries.
- `flush`=1 at edge: state EMPTY, `out_valid`=0 next cycle; an input handshaking in the same cycle is dropped; `in_ready`=1 next cycle. `rst` has priority over `flush`.
- Simultaneous accept and drain in FULL cannot occur (`in_ready`=0).

## Structure
- Package `opcode_type`: `opcode_t` gains `is_muldiv`; add named constants `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_BRANCH`, `OPC_LOAD`, `OPC_STORE`, `OPC_OP_IMM`, `OPC_OP`, `OPC_MISC_MEM`, `OPC_SYSTEM` (7-bit) and `F7_BASE`, `F7_ALT`, `F7_MULDIV`.
- Sub-module `opcode_classify`: purely combinational, instr + parameters -> `opcode_t`, illegal. The stage module owns the skid buffer and handshake.

## Test plan
- Reset: `rst`=0 for 3 cycles with `in_valid`=1 -> `out_valid`=0, `in_ready`=0 throughout; `in_ready`=1 one cycle after release.
- Stream ADDI 0x00500093, LUI 0x123450B7, ADD 0x002081B3 back-to-back with `out_ready`=1 -> each out one cycle later; only `is_imm_arith_type`/`is_lui`/`is_reg_arith_type` set respectively, `out_illegal`=0, PCs match.
- MUL 0x02208133 with `ENABLE_M`=1 -> `is_muldiv`=1; same word with `ENABLE_M`=0 -> `out_illegal`=1, `out_opcode`=0; 0x00000001 (C-form) and 0x0000007F -> illegal.
- Back-pressure: `out_ready`=0 while 3 words offered -> 2 accepted, `in_ready`=0 after second; release -> exactly those 2 emitted in order, then third accepted.
- `flush`=1 in FULL with `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1; nothing from before flush ever emitted.
- Random valid/ready for 10k words vs. scoreboard -> ordering, no loss, no duplication.
